// File: rtl/spmv_val_arb_pkg.sv
// Shared types and width helpers for the SpMV Val-port read arbiter.
package spmv_val_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Width of a requester id; a single requester still needs one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spmv_val_rd_arbiter_if.sv
// Kernel-side AR/R bundle plus the HBM master port of the Val read arbiter.
interface spmv_val_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 48,
  parameter int DATA_W  = 256
);
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]      s_arlen;
  logic [NUM_REQ*3-1:0]      s_arsize;
  logic [NUM_REQ*2-1:0]      s_arburst;
  logic [NUM_REQ-1:0]        s_arvalid;
  logic [NUM_REQ-1:0]        s_arready;
  logic [NUM_REQ*DATA_W-1:0] s_rdata;
  logic [NUM_REQ*2-1:0]      s_rresp;
  logic [NUM_REQ-1:0]        s_rlast;
  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready;

  logic [ADDR_W-1:0]   m_araddr;
  logic [7:0]          m_arlen;
  logic [2:0]          m_arsize;
  logic [1:0]          m_arburst;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic                m_rvalid;
  logic                m_rready;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  // Every channel: a transfer happens on a rising clk with valid & ready both
  // high; a raised valid and its payload hold until that transfer completes.
  modport master (
    input  s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    output s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    output s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    input  s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/spmv_id_fifo.sv
// Synchronous FIFO recording the order in which requesters were granted.
module spmv_id_fifo
  import spmv_val_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // The extra MSB tells a full FIFO from an empty one when the addresses match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/spmv_val_rd_arbiter.sv
// Round-robin AR arbiter and in-order R demux sharing the HBM Val read port.
module spmv_val_rd_arbiter
  import spmv_val_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 48,
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  spmv_val_rd_arbiter_if.master bus,
  output arb_state_e            dbg_state_o
);
  localparam int ID_W = id_width(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;

  logic [ID_W-1:0]    sel_id, head_id;
  logic               sel_found, grant;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NUM_REQ-1:0] arready, rvalid;
  logic               m_rready;

  always_comb begin : rr_select
    logic [ID_W-1:0] cand;
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!sel_found && bus.s_arvalid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign grant = (state_q == IDLE) && sel_found && !fifo_full && !rst;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arready   = '0;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          arready[sel_id] = 1'b1;
          fifo_push       = 1'b1;
          gnt_id_d        = sel_id;
          araddr_d        = bus.s_araddr[sel_id*ADDR_W +: ADDR_W];
          arlen_d         = bus.s_arlen[sel_id*8 +: 8];
          arsize_d        = bus.s_arsize[sel_id*3 +: 3];
          arburst_d       = bus.s_arburst[sel_id*2 +: 2];
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        // The pointer moves only once HBM takes the address, so nobody starves.
        if (bus.m_arready) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_id_q  <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_id_q  <= gnt_id_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  spmv_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (sel_id),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_id)
  );

  // HBM returns bursts in AR order, so the FIFO head owns every beat in flight.
  always_comb begin
    rvalid = '0;
    if (!fifo_empty) rvalid[head_id] = bus.m_rvalid;
  end

  assign m_rready = !fifo_empty && bus.s_rready[head_id];
  assign fifo_pop = bus.m_rvalid && m_rready && bus.m_rlast;

  assign bus.s_arready = arready;
  assign bus.s_rvalid  = rvalid;
  assign bus.s_rdata   = {NUM_REQ{bus.m_rdata}};
  assign bus.s_rresp   = {NUM_REQ{bus.m_rresp}};
  assign bus.s_rlast   = {NUM_REQ{bus.m_rlast}};
  assign bus.m_rready  = m_rready;

  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = arlen_q;
  assign bus.m_arsize  = arsize_q;
  assign bus.m_arburst = arburst_q;
  assign bus.m_arvalid = (state_q == ISSUE);

  assign bus.m_awaddr  = '0;
  assign bus.m_awlen   = '0;
  assign bus.m_awsize  = '0;
  assign bus.m_awburst = '0;
  assign bus.m_awvalid = 1'b0;
  assign bus.m_wdata   = '0;
  assign bus.m_wstrb   = '0;
  assign bus.m_wlast   = 1'b0;
  assign bus.m_wvalid  = 1'b0;
  assign bus.m_bready  = 1'b1;

  assign dbg_state_o = state_q;
endmodule
